sram_share_arb: RTL and testbench
=================================

SRAM_SHARE_ARB -- requirements
Module: sram_share_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the SRAM word width and the width of all data and bit-enable ports.
REQ-002 Parameter NUM_WORDS, default 1024, SHALL set the SRAM depth; ADDR_WIDTH = $clog2(NUM_WORDS).
REQ-003 Parameter LOCK_ADDR, default 100, SHALL set the write-once protected word address.
REQ-004 Ports SHALL be:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  [1:0]  per-requester request valid.
- req_ready_o  out  [1:0]  per-requester grant, same-cycle handshake.
- req_we_i  in  [1:0]  1 = write, 0 = read.
- req_addr_i  in  [1:0][ADDR_WIDTH]  word address.
- req_wdata_i  in  [1:0][DATA_WIDTH]  write data.
- req_be_i  in  [1:0][DATA_WIDTH]  per-bit write enable.
- rsp_valid_o  out  [1:0]  response strobe to the granted requester.
- rsp_rdata_o  out  [DATA_WIDTH]  read data, shared by both requesters.
- rsp_err_o  out  1  response error flag.
- sram_req_o, sram_we_o  out  1  SRAM macro request and write enable.
- sram_addr_o  out  ADDR_WIDTH  SRAM address.
- sram_wdata_o, sram_be_o  out  DATA_WIDTH  SRAM write data and bit enable.
- sram_rdata_i  in  DATA_WIDTH  SRAM read data, valid one cycle after a read request.

Function
REQ-005 A request SHALL be accepted in a cycle where req_valid_i[n] and req_ready_o[n] are both 1; at most one requester is accepted per cycle.
REQ-006 req_ready_o SHALL be combinational from req_valid_i and the round-robin pointer; a lone valid requester SHALL be granted the same cycle.
REQ-007 When both requesters are valid, the grant SHALL go to the requester not granted most recently; the pointer SHALL update only on accept.
REQ-008 On accept, sram_req_o SHALL be 1 in the same cycle; sram_we_o, sram_addr_o, sram_wdata_o and sram_be_o SHALL be driven from the granted requester, otherwise all 0.
REQ-009 Every accepted request SHALL produce exactly one rsp_valid_o pulse to its requester, exactly one cycle after accept; a write response carries rsp_rdata_o = 0.
REQ-010 rsp_rdata_o SHALL equal sram_rdata_i during a read response and 0 otherwise.
REQ-011 Back-to-back accepts on consecutive cycles SHALL be supported with no bubble; throughput is 1 request per cycle.
REQ-012 An accepted access with addr >= NUM_WORDS (non-power-of-2 depth) SHALL NOT assert sram_req_o; its response SHALL carry rsp_err_o = 1.

Reset
REQ-013 While rst_ni = 0: req_ready_o = 0, rsp_valid_o = 0, rsp_err_o = 0, sram_req_o = 0, round-robin pointer = requester 0, lock flag cleared.
REQ-014 A response pending when reset asserts SHALL be dropped; the first cycle after reset release SHALL accept new requests.

Configuration
REQ-015 Macro SRAM_ARB_WLOCK_EN defined: the first accepted write to LOCK_ADDR SHALL pass to the SRAM and set a sticky lock flag.
REQ-016 With the lock flag set, each later write to LOCK_ADDR SHALL keep sram_req_o = 0 and SHALL respond with rsp_err_o = 1; reads of LOCK_ADDR are unaffected.
REQ-017 If both requesters target LOCK_ADDR in the same cycle, only the granted write SHALL count as the first write.
REQ-018 Macro SRAM_ARB_WLOCK_EN undefined: no lock flag, and writes to LOCK_ADDR SHALL behave as writes to any other address.

Structure
REQ-019 Package sram_arb_pkg SHALL hold the request struct typedef (we, addr, wdata, be) and the requester-count constant (2).
REQ-020 The round-robin selector SHALL be a sub-module sram_rr_pick (valid[1:0], pointer in, one-hot grant out); everything else SHALL be flat in sram_share_arb.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Req0 writes 0xA5 to addr 5, then reads addr 5 -> rsp_valid_o[0] is set one cycle after each accept; the read returns 0xA5 with rsp_err_o = 0.
- Both requesters valid for 4 cycles -> grants alternate 0,1,0,1; there is one response per accept.
- With WLOCK: write 0x11 to addr 100, then write 0x22 to addr 100, then read addr 100 -> the second write has sram_req_o = 0 and rsp_err_o = 1; the read returns 0x11.
- Without WLOCK: the same sequence -> the read returns 0x22; rsp_err_o = 0 throughout.
- rst_ni is pulsed low in the cycle after a read accept -> no rsp_valid_o; the lock flag is cleared, so a write to addr 100 then succeeds.
- NUM_WORDS = 1000, access addr 1010 -> sram_req_o = 0 and rsp_err_o = 1.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM arbiter.
// req_t is sized for the widest supported configuration; narrower ports are zero-extended into it.
package sram_arb_pkg;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned REQ_DW_MAX = 64;
    localparam int unsigned REQ_AW_MAX = 32;

    typedef struct packed {
        logic                  we;
        logic [REQ_AW_MAX-1:0] addr;
        logic [REQ_DW_MAX-1:0] wdata;
        logic [REQ_DW_MAX-1:0] be;
    } req_t;

endpackage

// File: rtl/sram_rr_pick.sv
// Two-way round-robin selector: ptr_i names the requester that wins a tie.
// The grant is one-hot, or zero when nobody is valid.
module sram_rr_pick (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        if (valid_i == 2'b11) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end else begin
            gnt_o = valid_i;
        end
    end

endmodule

// File: rtl/sram_share_arb.sv
// Shares one single-port SRAM macro between two requesters with a same-cycle handshake.
// Define SRAM_ARB_WLOCK_EN to make LOCK_ADDR write-once until the next reset.
module sram_share_arb
    import sram_arb_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 64,
    parameter  int unsigned NUM_WORDS  = 1024,
    parameter  int unsigned LOCK_ADDR  = 100,
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_WORDS)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [1:0]                 req_valid_i,
    output logic [1:0]                 req_ready_o,
    input  logic [1:0]                 req_we_i,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr_i,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata_i,
    input  logic [1:0][DATA_WIDTH-1:0] req_be_i,
    output logic [1:0]                 rsp_valid_o,
    output logic [DATA_WIDTH-1:0]      rsp_rdata_o,
    output logic                       rsp_err_o,
    output logic                       sram_req_o,
    output logic                       sram_we_o,
    output logic [ADDR_WIDTH-1:0]      sram_addr_o,
    output logic [DATA_WIDTH-1:0]      sram_wdata_o,
    output logic [DATA_WIDTH-1:0]      sram_be_o,
    input  logic [DATA_WIDTH-1:0]      sram_rdata_i
);

    logic       ptr_q, ptr_d;
    logic [1:0] gnt;
    logic [1:0] rsp_vld_q, rsp_vld_d;
    logic       rsp_rd_q, rsp_rd_d;
    logic       rsp_err_q, rsp_err_d;
    logic       accept;
    logic       oob;
    logic       blocked;
    logic       fire;
    req_t       sel;

    sram_rr_pick u_pick (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt)
    );

    // Grants are suppressed while reset is held so nothing is accepted then.
    assign req_ready_o = rst_ni ? gnt : 2'b00;
    assign accept      = |req_ready_o;

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel.we    = req_we_i[i];
                sel.addr  = REQ_AW_MAX'(req_addr_i[i]);
                sel.wdata = REQ_DW_MAX'(req_wdata_i[i]);
                sel.be    = REQ_DW_MAX'(req_be_i[i]);
            end
        end
    end

    assign oob = sel.addr >= REQ_AW_MAX'(NUM_WORDS);

`ifdef SRAM_ARB_WLOCK_EN
    logic lock_q, lock_d;
    logic lock_hit;

    assign lock_hit = sel.we && (sel.addr == REQ_AW_MAX'(LOCK_ADDR));
    assign blocked  = lock_q && lock_hit;

    always_comb begin
        lock_d = lock_q;
        if (accept && lock_hit && !oob) begin
            lock_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    assign blocked = 1'b0;
`endif

    assign fire = accept && !oob && !blocked;

    always_comb begin
        sram_req_o   = fire;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (fire) begin
            sram_we_o    = sel.we;
            sram_addr_o  = sel.addr[ADDR_WIDTH-1:0];
            sram_wdata_o = sel.wdata[DATA_WIDTH-1:0];
            sram_be_o    = sel.be[DATA_WIDTH-1:0];
        end
    end

    // Priority passes to the requester that was not just granted.
    always_comb begin
        ptr_d     = ptr_q;
        rsp_vld_d = req_ready_o;
        rsp_rd_d  = fire && !sel.we;
        rsp_err_d = accept && (oob || blocked);
        if (accept) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= 1'b0;
            rsp_vld_q <= '0;
            rsp_rd_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_rd_q  <= rsp_rd_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_vld_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rd_q ? sram_rdata_i : '0;

endmodule

// File: tb/tb_sram_share_arb.sv
// Bench for sram_share_arb: a request-level model checks every cycle, directed vectors pin literals.
// Honours SRAM_ARB_WLOCK_EN in the same way as the design.
module tb_sram_share_arb;

    localparam int unsigned DW = 64;
    localparam int unsigned NW = 1024;
    localparam int unsigned AW = 10;
    localparam int unsigned LA = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [1:0]         req_valid, req_we, req_ready, rsp_valid;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][DW-1:0] req_wdata, req_be;
    logic [DW-1:0]      rsp_rdata, sram_wdata, sram_be;
    logic [DW-1:0]      sram_rdata = '0;
    logic               rsp_err, sram_req, sram_we;
    logic [AW-1:0]      sram_addr;

    logic [1:0]         vb, web, readyb, rvb;
    logic [1:0][AW-1:0] addrb;
    logic [1:0][DW-1:0] wdb, beb;
    logic [DW-1:0]      rdatab, swdb, sbeb;
    logic               errb, sreqb, sweb;
    logic [AW-1:0]      saddrb;
    logic [DW-1:0]      srdb;

    assign srdb = 64'hDEAD_BEEF_0BAD_F00D;

    sram_share_arb #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .LOCK_ADDR(LA)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
    );

    sram_share_arb #(.DATA_WIDTH(DW), .NUM_WORDS(1000), .LOCK_ADDR(LA)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(vb), .req_ready_o(readyb), .req_we_i(web),
        .req_addr_i(addrb), .req_wdata_i(wdb), .req_be_i(beb),
        .rsp_valid_o(rvb), .rsp_rdata_o(rdatab), .rsp_err_o(errb),
        .sram_req_o(sreqb), .sram_we_o(sweb), .sram_addr_o(saddrb),
        .sram_wdata_o(swdb), .sram_be_o(sbeb), .sram_rdata_i(srdb)
    );

    // SRAM macro behaviour: bit-masked write, registered read.
    logic [DW-1:0] mem [NW] = '{default: '0};
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) mem[sram_addr] <= (mem[sram_addr] & ~sram_be) | (sram_wdata & sram_be);
            else         sram_rdata <= mem[sram_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who is served, what the memory holds, what the answer must be.
    logic [DW-1:0] exp_mem [NW] = '{default: '0};
    int            last_gnt   = 1;
    logic          lock_m     = 1'b0;
    logic [1:0]    pend_v     = '0;
    logic          pend_err   = 1'b0;
    logic [DW-1:0] pend_rdata = '0;

    always @(negedge clk) begin : model
        int         g;
        logic [1:0] exp_gnt;
        logic       hit, blk, busy;
        if (!rst_n) begin
            last_gnt = 1; lock_m = 1'b0; pend_v = '0; pend_err = 1'b0; pend_rdata = '0;
            chk("rst_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_sram_req", sram_req, 0);
        end else begin
            chk("rsp_valid", rsp_valid, pend_v);
            chk("rsp_err", rsp_err, pend_err);
            chk("rsp_rdata", rsp_rdata, pend_rdata);
            g = -1;
            if (req_valid == 2'b11) g = 1 - last_gnt;
            else if (req_valid[0])  g = 0;
            else if (req_valid[1])  g = 1;
            exp_gnt = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
            chk("req_ready", req_ready, exp_gnt);
            pend_v = exp_gnt; pend_err = 1'b0; pend_rdata = '0;
            busy = 1'b0;
            if (g >= 0) begin
                last_gnt = g;
                hit = req_we[g] && (req_addr[g] == AW'(LA));
`ifdef SRAM_ARB_WLOCK_EN
                blk = lock_m && hit;
`else
                blk = 1'b0;
`endif
                if (blk) begin
                    pend_err = 1'b1;
                end else begin
                    busy = 1'b1;
                    chk("sram_req", sram_req, 1);
                    chk("sram_we", sram_we, req_we[g]);
                    chk("sram_addr", sram_addr, req_addr[g]);
                    chk("sram_wdata", sram_wdata, req_wdata[g]);
                    chk("sram_be", sram_be, req_be[g]);
                    if (req_we[g]) begin
                        exp_mem[req_addr[g]] = (exp_mem[req_addr[g]] & ~req_be[g]) | (req_wdata[g] & req_be[g]);
                        if (hit) lock_m = 1'b1;
                    end else begin
                        pend_rdata = exp_mem[req_addr[g]];
                    end
                end
            end
            if (!busy) begin
                chk("sram_idle_req", sram_req, 0);
                chk("sram_idle_bus", {sram_we, sram_addr} | 64'(sram_wdata | sram_be), 0);
            end
        end
    end

    task automatic idle();
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    endtask

    task automatic idle_b();
        vb = '0; web = '0; addrb = '0; wdb = '0; beb = '0;
    endtask

    task automatic set_req(input int n, input logic we, input int addr, input logic [63:0] wd);
        req_valid[n] = 1'b1; req_we[n] = we; req_addr[n] = AW'(addr);
        req_wdata[n] = wd; req_be[n] = '1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle(); idle_b();
        repeat (2) tick();

        // Grants alternate from the very first cycle out of reset.
        set_req(0, 1'b0, 1, '0);
        set_req(1, 1'b0, 2, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("alt_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        idle();
        @(negedge clk);
        chk("alt_last_rsp", rsp_valid, 2'b10);
        tick();

        // Write then read back addr 5.
        set_req(0, 1'b1, 5, 64'hA5);
        @(negedge clk);
        chk("wr5_ready", req_ready, 2'b01);
        chk("wr5_sram_req", sram_req, 1);
        tick();
        idle();
        set_req(0, 1'b0, 5, '0);
        @(negedge clk);
        chk("wr5_rsp", rsp_valid, 2'b01);
        chk("wr5_rdata", rsp_rdata, 0);
        tick();
        idle();
        @(negedge clk);
        chk("rd5_rsp", rsp_valid, 2'b01);
        chk("rd5_rdata", rsp_rdata, 64'hA5);
        chk("rd5_err", rsp_err, 0);
        tick();

        // Write-once sequence on LOCK_ADDR.
        set_req(0, 1'b1, LA, 64'h11);
        tick();
        idle();
        set_req(1, 1'b1, LA, 64'h22);
        @(negedge clk);
`ifdef SRAM_ARB_WLOCK_EN
        chk("lock_wr2_sram_req", sram_req, 0);
`else
        chk("lock_wr2_sram_req", sram_req, 1);
`endif
        tick();
        idle();
        set_req(0, 1'b0, LA, '0);
        @(negedge clk);
        chk("lock_wr2_rsp", rsp_valid, 2'b10);
`ifdef SRAM_ARB_WLOCK_EN
        chk("lock_wr2_err", rsp_err, 1);
`else
        chk("lock_wr2_err", rsp_err, 0);
`endif
        tick();
        idle();
        @(negedge clk);
`ifdef SRAM_ARB_WLOCK_EN
        chk("lock_rd_rdata", rsp_rdata, 64'h11);
`else
        chk("lock_rd_rdata", rsp_rdata, 64'h22);
`endif
        chk("lock_rd_err", rsp_err, 0);
        tick();

        // Reset pulse right after a read accept drops the response and clears the lock.
        set_req(0, 1'b0, 5, '0);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstp_rsp", rsp_valid, 0);
        chk("rstp_ready", req_ready, 0);
        tick();
        rst_n = 1'b1;
        idle();
        set_req(0, 1'b1, LA, 64'h33);
        @(negedge clk);
        chk("rstp_wr_sram_req", sram_req, 1);
        tick();
        idle();
        set_req(0, 1'b0, LA, '0);
        @(negedge clk);
        chk("rstp_wr_err", rsp_err, 0);
        tick();
        idle();
        @(negedge clk);
        chk("rstp_rd_rdata", rsp_rdata, 64'h33);
        tick();

        // Mixed back-to-back traffic with partial bit enables.
        for (int i = 0; i < 24; i++) begin
            req_valid    = 2'((i % 3) + 1);
            req_we       = 2'((i * 3) % 4);
            req_addr[0]  = AW'(200 + (i % 5));
            req_addr[1]  = AW'(200 + ((i + 2) % 5));
            req_wdata[0] = 64'h0101_0101_0101_0101 * 64'(i + 1);
            req_wdata[1] = 64'hF0E1_D2C3_B4A5_9687 ^ 64'(i);
            req_be[0]    = 64'h00FF_00FF_FFFF_0000 ^ 64'(i);
            req_be[1]    = 64'hFFFF_0000_0F0F_F0F0;
            tick();
        end
        idle();
        repeat (2) tick();

        // Non-power-of-2 depth: addr 1010 is out of range, 999 is not.
        vb[0] = 1'b1; web[0] = 1'b0; addrb[0] = AW'(1010);
        @(negedge clk);
        chk("oob_ready", readyb, 2'b01);
        chk("oob_sram_req", sreqb, 0);
        chk("oob_sram_addr", saddrb, 0);
        tick();
        idle_b();
        @(negedge clk);
        chk("oob_rsp", rvb, 2'b01);
        chk("oob_err", errb, 1);
        chk("oob_rdata", rdatab, 0);
        tick();
        vb[1] = 1'b1; web[1] = 1'b1; addrb[1] = AW'(999); wdb[1] = 64'h5; beb[1] = '1;
        @(negedge clk);
        chk("inr_sram_req", sreqb, 1);
        chk("inr_sram_addr", saddrb, 999);
        tick();
        idle_b();
        vb[0] = 1'b1; addrb[0] = AW'(999);
        @(negedge clk);
        chk("inr_wr_err", errb, 0);
        chk("inr_wr_rdata", rdatab, 0);
        tick();
        idle_b();
        @(negedge clk);
        chk("inr_rd_err", errb, 0);
        chk("inr_rd_rdata", rdatab, 64'hDEAD_BEEF_0BAD_F00D);
        tick();

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
